// File: rtl/pic_sync_pkg.sv
// Shared constants for the synchronous priority interrupt controller core:
// register map, command opcodes, FSM encoding and status field layout.
package pic_sync_pkg;
  localparam logic [1:0] WA_IMR   = 2'd0;
  localparam logic [1:0] WA_VBASE = 2'd1;
  localparam logic [1:0] WA_MODE  = 2'd2;
  localparam logic [1:0] WA_CMD   = 2'd3;

  localparam logic [1:0] RA_IRR  = 2'd0;
  localparam logic [1:0] RA_ISR  = 2'd1;
  localparam logic [1:0] RA_IMR  = 2'd2;
  localparam logic [1:0] RA_STAT = 2'd3;

  localparam logic [3:0] OP_INIT   = 4'd0;
  localparam logic [3:0] OP_NSEOI  = 4'd1;
  localparam logic [3:0] OP_SEOI   = 4'd2;
  localparam logic [3:0] OP_RNSEOI = 4'd3;
  localparam logic [3:0] OP_RSEOI  = 4'd4;
  localparam logic [3:0] OP_SETPRI = 4'd5;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT_ACK2 = 2'd1} fsm_e;

  localparam int ST_FSM_LSB  = 14;
  localparam int ST_SPUR_BIT = 13;
  localparam int ST_CUR_LSB  = 8;
  localparam int ST_PRIO_LSB = 4;

  localparam int MODE_LEVEL = 0;
  localparam int MODE_AEOI  = 1;
  localparam int MODE_ROT   = 2;
endpackage

// File: rtl/pic_prio_resolver.sv
// Rotating priority encoder: channel prio_base+1 is highest, descending
// cyclically; rank is the winner's distance from the highest slot.
module pic_prio_resolver #(
  parameter  int NUM_IRQ = 8,
  localparam int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [ID_W-1:0]    prio_base,
  output logic               valid,
  output logic [ID_W-1:0]    id,
  output logic [ID_W-1:0]    rank
);
  int unsigned ch;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    rank  = '0;
    ch    = 0;
    for (int k = NUM_IRQ-1; k >= 0; k--) begin
      ch = int'(prio_base) + 1 + k;
      if (ch >= NUM_IRQ) ch = ch - NUM_IRQ;
      if (req[ch[ID_W-1:0]]) begin
        valid = 1'b1;
        id    = ch[ID_W-1:0];
        rank  = k[ID_W-1:0];
      end
    end
  end
endmodule

// File: rtl/pic_sync_core.sv
// Single-clock priority interrupt controller: edge/level capture, masking,
// fully nested priority with rotation, AEOI and a two-strobe acknowledge.
module pic_sync_core import pic_sync_pkg::*; #(
  parameter  int NUM_IRQ = 8,
  localparam int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [15:0]        wr_data,
  input  logic [1:0]         rd_addr,
  output logic [15:0]        rd_data,
  input  logic               inta_i,
  output logic               int_o,
  output logic [7:0]         vector_o,
  output logic               vector_valid_o
);
  logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d, irq_d1_q;
  logic [NUM_IRQ-1:0] isr_set, isr_clr, irr_clr, pend_req;
  logic [7:0]         vbase_q, vbase_d, vec_q, vec_d, vec_w;
  logic [2:0]         mode_q, mode_d;
  logic [ID_W-1:0]    pbase_q, pbase_d, cur_id_q, cur_id_d;
  logic [ID_W-1:0]    pend_id, pend_rank, isr_id, isr_rank, lvl_id;
  logic               spur_q, spur_d, int_q, int_d, vvld_q, vvld_d;
  logic               pend_vld, isr_vld, elig, cmd_en, init, lvl_ok, unused_wr;
  logic [3:0]         op, lvl;
  logic [15:0]        rd_q, rd_d, stat;
  fsm_e               fsm_q, fsm_d;

  assign pend_req  = irr_q & ~imr_q;
  assign cmd_en    = wr_en && (wr_addr == WA_CMD);
  assign op        = wr_data[15:12];
  assign lvl       = wr_data[3:0];
  assign lvl_ok    = {1'b0, lvl} < 5'(NUM_IRQ);
  assign lvl_id    = lvl[ID_W-1:0];
  assign init      = cmd_en && (op == OP_INIT);
  assign unused_wr = ^wr_data[11:8];

  pic_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_pend (
    .req(pend_req), .prio_base(pbase_q), .valid(pend_vld), .id(pend_id), .rank(pend_rank));
  pic_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_isr (
    .req(isr_q), .prio_base(pbase_q), .valid(isr_vld), .id(isr_id), .rank(isr_rank));

  // Fully nested: a request must strictly outrank everything in service.
  assign elig = pend_vld && (!isr_vld || (pend_rank < isr_rank));

  always_comb begin
    imr_d    = imr_q;
    vbase_d  = vbase_q;
    mode_d   = mode_q;
    pbase_d  = pbase_q;
    cur_id_d = cur_id_q;
    spur_d   = spur_q;
    fsm_d    = fsm_q;
    vec_d    = '0;
    vvld_d   = 1'b0;
    isr_set  = '0;
    isr_clr  = '0;
    irr_clr  = '0;
    vec_w    = vbase_q;
    vec_w[ID_W-1:0] = cur_id_q;

    case (fsm_q)
      ST_IDLE: if (inta_i) begin
        fsm_d = ST_WAIT_ACK2;
        if (elig) begin
          cur_id_d         = pend_id;
          isr_set[pend_id] = 1'b1;
          irr_clr[pend_id] = !mode_q[MODE_LEVEL];
          spur_d           = 1'b0;
        end else begin
          cur_id_d = ID_W'(NUM_IRQ-1);
          spur_d   = 1'b1;
        end
      end
      ST_WAIT_ACK2: if (inta_i) begin
        fsm_d  = ST_IDLE;
        vec_d  = vec_w;
        vvld_d = 1'b1;
        if (mode_q[MODE_AEOI] && !spur_q) begin
          isr_clr[cur_id_q] = 1'b1;
          if (mode_q[MODE_ROT]) pbase_d = cur_id_q;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase

    // Register writes come after the handshake so command rotation wins.
    if (wr_en) begin
      case (wr_addr)
        WA_IMR:   imr_d   = wr_data[NUM_IRQ-1:0];
        WA_VBASE: vbase_d = wr_data[7:0];
        WA_MODE:  mode_d  = wr_data[2:0];
        default: begin
          case (op)
            OP_NSEOI:  if (isr_vld) isr_clr[isr_id] = 1'b1;
            OP_SEOI:   if (lvl_ok) isr_clr[lvl_id] = 1'b1;
            OP_RNSEOI: if (isr_vld) begin
              isr_clr[isr_id] = 1'b1;
              pbase_d         = isr_id;
            end
            OP_RSEOI:  if (lvl_ok && isr_vld) begin
              isr_clr[lvl_id] = 1'b1;
              pbase_d         = lvl_id;
            end
            OP_SETPRI: if (lvl_ok) pbase_d = lvl_id;
            default: ;
          endcase
        end
      endcase
    end

    isr_d = (isr_q & ~isr_clr) | isr_set;
    if (mode_q[MODE_LEVEL]) irr_d = irq_i;
    else                    irr_d = (irr_q & ~irr_clr) | (irq_i & ~irq_d1_q);

    if (init) begin
      irr_d   = '0;
      isr_d   = '0;
      imr_d   = '1;
      pbase_d = ID_W'(NUM_IRQ-1);
      fsm_d   = ST_IDLE;
      vec_d   = '0;
      vvld_d  = 1'b0;
    end

    int_d = (fsm_q == ST_IDLE) && elig && !inta_i && !init;

    stat = '0;
    stat[ST_FSM_LSB +: 2]  = fsm_q;
    stat[ST_SPUR_BIT]      = spur_q;
    stat[ST_CUR_LSB +: 4]  = 4'(cur_id_q);
    stat[ST_PRIO_LSB +: 4] = 4'(pbase_q);
    case (rd_addr)
      RA_IRR:  rd_d = 16'(irr_q);
      RA_ISR:  rd_d = 16'(isr_q);
      RA_IMR:  rd_d = 16'(imr_q);
      default: rd_d = stat;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irr_q    <= '0;
      isr_q    <= '0;
      imr_q    <= '1;
      irq_d1_q <= '0;
      vbase_q  <= '0;
      mode_q   <= '0;
      pbase_q  <= ID_W'(NUM_IRQ-1);
      cur_id_q <= '0;
      spur_q   <= 1'b0;
      fsm_q    <= ST_IDLE;
      int_q    <= 1'b0;
      vec_q    <= '0;
      vvld_q   <= 1'b0;
      rd_q     <= '0;
    end else begin
      irr_q    <= irr_d;
      isr_q    <= isr_d;
      imr_q    <= imr_d;
      irq_d1_q <= irq_i;
      vbase_q  <= vbase_d;
      mode_q   <= mode_d;
      pbase_q  <= pbase_d;
      cur_id_q <= cur_id_d;
      spur_q   <= spur_d;
      fsm_q    <= fsm_d;
      int_q    <= int_d;
      vec_q    <= vec_d;
      vvld_q   <= vvld_d;
      rd_q     <= rd_d;
    end
  end

  assign int_o          = int_q;
  assign vector_o       = vec_q;
  assign vector_valid_o = vvld_q;
  assign rd_data        = rd_q;
endmodule
